// File: rtl/serialize_1d_array.sv
// Serializes one packed vector of COLS elements into an element stream,
// column 0 first, with index and last markers on a valid/ready handshake.
module serialize_1d_array #(
    parameter int BIT_WIDTH = 4,
    parameter int COLS      = 8,
    localparam int IDX_WIDTH = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [COLS*BIT_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [BIT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_WIDTH-1:0]      out_index,
    output logic                      out_last
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(COLS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [COLS*BIT_WIDTH-1:0]  buf_q;
    logic [COLS*BIT_WIDTH-1:0]  buf_d;
    logic [IDX_WIDTH-1:0]       idx_q;
    logic [IDX_WIDTH-1:0]       idx_d;

    logic sending;
    logic at_last;
    logic xfer;
    logic accept;

    assign sending = (state_q == SEND);
    assign at_last = (idx_q == LAST_IDX);
    assign xfer    = sending && out_ready;

    // The final handshake of a vector frees the buffer in the same cycle,
    // so a waiting vector can be loaded with no bubble.
    assign in_ready = !sending || (at_last && out_ready);
    assign accept   = in_valid && in_ready;

    assign out_valid = sending;
    assign out_index = idx_q;
    assign out_last  = sending && at_last;
    assign out_data  = buf_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        if (accept) begin
            buf_d   = in_data;
            idx_d   = '0;
            state_d = SEND;
        end else if (xfer) begin
            if (at_last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: doc/serialize_1d_array.md
Name: serialize_1d_array

Overview:
Downstream consumer of the packed 1D array produced by the 2D-to-1D converter. Accepts one packed vector of COLS elements via a valid/ready handshake. Streams the elements out one per cycle, column 0 first (LSB slice first), with its own valid/ready handshake, an element index and a last flag. Sits between the array-packing stage and any element-serial datapath, such as an MAC or a narrow bus.

Parameters:
BIT_WIDTH, 4, width of one element in bits (>=1)
COLS, 8, number of elements per packed vector (>=1)
IDX_WIDTH, derived localparam = max(1, $clog2(COLS)), width of out_index

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  COLS*BIT_WIDTH  packed vector; element i at bits [i*BIT_WIDTH +: BIT_WIDTH]
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a vector this cycle
out_data  output  BIT_WIDTH  current element
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
out_index  output  IDX_WIDTH  column index of current element
out_last  output  1  current element is column COLS-1

Behaviour:
- Reset and clock/reset scheme:
  - One clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
  - While rst_n is low at an edge, all registers clear:
    - state=IDLE
    - vector buffer=0
    - index=0
  - Resulting output values after reset: out_valid=0, out_data=0, out_index=0, out_last=0, in_ready=1.
- States: IDLE, SEND.
- Input accept: accept = in_valid && in_ready.
- in_ready (combinational from state and outputs): in_ready = (state==IDLE) || (state==SEND && out_last && out_ready).
- IDLE:
  - On accept: buffer <= in_data, index <= 0, state <= SEND.
  - Latency: first element appears with out_valid=1 on the cycle after acceptance.
- SEND outputs:
  - out_valid=1.
  - out_data = buffer[index*BIT_WIDTH +: BIT_WIDTH].
  - out_index = index.
  - out_last = (index==COLS-1).
- SEND, element transfer (out_ready=1), not last: index <= index+1.
- SEND, element transfer, last:
  - If in_valid=1 in the same cycle: new vector captured, index <= 0, stay in SEND. No bubble between vectors.
  - Else: state <= IDLE, out_valid drops next cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable; index does not advance.
- Throughput and ignored input:
  - With out_ready held high, one vector is emitted every COLS cycles, with no idle cycles between back-to-back vectors.
  - in_data is ignored in any cycle without accept. The buffer is never modified mid-vector.
- Outputs when idle: with out_valid=0, out_data retains the last driven buffer slice (0 after reset). Consumers must qualify out_data with out_valid.
- COLS=1: every element has out_last=1; in_ready = IDLE || out_ready; sustained rate is one vector per cycle.
- Reset mid-vector:
  - The partially sent vector is discarded.
  - The next cycle shows out_valid=0 and in_ready=1.
  - The next accepted vector starts at column 0.
- No arithmetic on data; slicing only. out_index wraps only via the last-element rule, never by counter overflow.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0; nothing is captured.
2. BIT_WIDTH=4, COLS=8, in_data=32'h76543210 accepted, out_ready=1 ->
   - next 8 cycles: out_data=0,1,...,7 and out_index=0..7;
   - out_last=1 only on element 7;
   - out_valid=0 on the following cycle.
3. Backpressure: same vector; out_ready=0 for 4 cycles while element 3 is shown -> out_data=3, out_index=3 held all 4 cycles; next transfer shows 4.
4. Back-to-back: 32'hFEDCBA98 presented with in_valid=1 throughout vector 1 ->
   - in_ready=0 until element 7's handshake, then accepted in that cycle;
   - 16 consecutive valid cycles with out_data 0..7 then 8..F;
   - out_last on the 8th and 16th cycles.
5. Input while busy: in_valid=1 with a changing in_data during elements 0..6 -> no accept, no corruption; only the value present at element 7's handshake is captured.
6. Reset mid-vector after elements 0..2 transferred -> the cycle after reset shows out_valid=0; new vector 32'hAAAA5555 then emits 5,5,5,5,A,A,A,A from index 0.
